// File: rtl/mod_symbol_source.sv
// PRBS15 symbol source for the QAM mapper: baud divider, bit-serial symbol assembly, valid/ready, overrun flag.
// Optional build macro SYM_SOURCE_GRAY_EN: Gray-code each I/Q half of sym_data at the output register.
module mod_symbol_source #(
  parameter int unsigned CLK_HZ    = 11059200,
  parameter logic [14:0] PRBS_SEED = 15'h7FFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mod_type,
  input  logic [1:0]       baud_rate,
  output logic [5:0]       sym_data,
  output logic [2:0]       sym_bits,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             sym_overrun,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam logic [13:0] LAST_1200 = 14'(CLK_HZ / 1200 - 1);
  localparam logic [13:0] LAST_2400 = 14'(CLK_HZ / 2400 - 1);
  localparam logic [13:0] LAST_4800 = 14'(CLK_HZ / 4800 - 1);
  localparam logic [13:0] LAST_9600 = 14'(CLK_HZ / 9600 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_PRES  = 2'd3;

  logic [13:0] div_cnt_reg;
  logic [13:0] div_last;
  logic [1:0]  baud_reg;
  logic        baud_chg;
  logic        tick;

  logic [1:0]  state_reg;
  logic [14:0] lfsr_reg;
  logic        nb;
  logic [5:0]  shift_reg;
  logic [5:0]  shift_next;
  logic [5:0]  sym_out_next;
  logic [2:0]  n_reg;
  logic [2:0]  n_sel;
  logic [2:0]  bit_cnt_reg;

  always_comb begin
    div_last = LAST_1200;
    case (baud_rate)
      2'b01:   div_last = LAST_2400;
      2'b10:   div_last = LAST_4800;
      2'b11:   div_last = LAST_9600;
      default: div_last = LAST_1200;
    endcase
  end

  // A rate change restarts the count from zero and suppresses the tick for that cycle.
  assign baud_chg = (baud_rate != baud_reg);
  assign tick     = enable && !baud_chg && (div_cnt_reg == div_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      baud_reg    <= 2'b00;
    end else begin
      baud_reg <= baud_rate;
      if (!enable || baud_chg || tick)
        div_cnt_reg <= '0;
      else
        div_cnt_reg <= div_cnt_reg + 14'd1;
    end
  end

  always_comb begin
    n_sel = 3'd2;
    case (mod_type)
      2'b01:   n_sel = 3'd4;
      2'b10:   n_sel = 3'd6;
      default: n_sel = 3'd2;
    endcase
  end

  assign nb         = lfsr_reg[14] ^ lfsr_reg[13];
  assign shift_next = {shift_reg[4:0], nb};

  function automatic logic [5:0] gray_halves(input logic [5:0] b, input logic [2:0] n);
    logic [5:0] g;
    g = b;
    case (n)
      3'd6:    g = {b[5:3] ^ {1'b0, b[5:4]}, b[2:0] ^ {1'b0, b[2:1]}};
      3'd4:    g = {2'b00, b[3:2] ^ {1'b0, b[3]}, b[1:0] ^ {1'b0, b[1]}};
      default: g = b;
    endcase
    return g;
  endfunction

`ifdef SYM_SOURCE_GRAY_EN
  assign sym_out_next = gray_halves(shift_next, n_reg);
`else
  assign sym_out_next = shift_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      lfsr_reg    <= PRBS_SEED;
      shift_reg   <= '0;
      n_reg       <= 3'd2;
      bit_cnt_reg <= '0;
      sym_data    <= '0;
      sym_bits    <= 3'd2;
      sym_valid   <= 1'b0;
      sym_overrun <= 1'b0;
      sym_cnt     <= '0;
    end else begin
      sym_overrun <= 1'b0;
      // Disabling abandons any partial symbol but keeps the LFSR so the stream resumes seamlessly.
      if (!enable) begin
        state_reg <= S_IDLE;
        sym_valid <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: state_reg <= S_WAIT;
          S_WAIT: begin
            if (tick) begin
              n_reg       <= n_sel;
              bit_cnt_reg <= n_sel;
              shift_reg   <= '0;
              state_reg   <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            lfsr_reg    <= {lfsr_reg[13:0], nb};
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg - 3'd1;
            if (bit_cnt_reg == 3'd1) begin
              sym_data  <= sym_out_next;
              sym_bits  <= n_reg;
              sym_valid <= 1'b1;
              state_reg <= S_PRES;
            end
          end
          S_PRES: begin
            // A tick here is dropped: no LFSR step, so the bit stream stays contiguous.
            if (tick)
              sym_overrun <= 1'b1;
            if (sym_ready) begin
              sym_valid <= 1'b0;
              sym_cnt   <= sym_cnt + CNT_W'(1);
              state_reg <= S_WAIT;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_symbol_source.sv
// Directed bench for mod_symbol_source: divider timing, PRBS symbol values, overrun, enable/reset and counter wrap.
`timescale 1ns/1ps
module tb_mod_symbol_source;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       mod_type = 2'b00;
  logic [1:0]       baud_rate = 2'b00;
  logic             sym_ready = 1'b1;
  logic [5:0]       sym_data;
  logic [2:0]       sym_bits;
  logic             sym_valid;
  logic             sym_overrun;
  logic [CNT_W-1:0] sym_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mod_symbol_source #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mod_type(mod_type), .baud_rate(baud_rate),
    .sym_data(sym_data), .sym_bits(sym_bits), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_overrun(sym_overrun), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sym_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] b);
    rst_n = 1'b0;
    enable = 1'b0;
    mod_type = m;
    baud_rate = b;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // QPSK stream from seed 7FFF: bits 1-14 zero, 15=1, 16-28 zero, 29=1, 30=1, 31-32 zero.
  function automatic logic [5:0] exp_qpsk(input int i);
    return (i == 8) ? 6'd2 : (i == 15) ? 6'd3 : 6'd0;
  endfunction

  function automatic logic [5:0] exp_16qam(input int i);
`ifdef SYM_SOURCE_GRAY_EN
    return (i == 4) ? 6'b000011 : 6'd0;
`else
    return (i == 4) ? 6'b000010 : 6'd0;
`endif
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, prev, k, ov, drop, chg, vcount;
    logic [5:0] d0;

    // Reset values while rst_n is held low
    repeat (2) @(negedge clk);
    check("rst_data", sym_data, 6'd0);
    check("rst_bits", sym_bits, 3'd2);
    check("rst_valid", sym_valid, 1'b0);
    check("rst_overrun", sym_overrun, 1'b0);
    check("rst_cnt", sym_cnt, 4'd0);

    // QPSK at 1200 baud, then a mid-count switch to 9600 baud
    do_reset(2'b00, 2'b00);
    sym_ready = 1'b1;
    enable = 1'b1;
    prev = 0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        repeat (100) @(negedge clk);
        baud_rate = 2'b11;
        k = cyc;
      end
      wait_valid((i <= 2) ? 9300 : 1300, at);
      check($sformatf("s1_sym%0d", i), sym_data, exp_qpsk(i));
      if (i == 1) check("s1_bits", sym_bits, 3'd2);
      if (i == 2) check("s1_spacing_1200", at - prev, 9216);
      if (i == 3) check("s1_baud_switch_tick", at - k, 1155);
      if (i > 3) check($sformatf("s1_spacing_9600_%0d", i), at - prev, 1152);
      prev = at;
    end
    @(negedge clk);
    check("s1_valid_drop", sym_valid, 1'b0);
    check("s1_cnt", sym_cnt, 4'd8);

    // 16QAM at 9600 baud: latency and values
    do_reset(2'b01, 2'b11);
    enable = 1'b1;
    k = cyc;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(1300, at);
      check($sformatf("s2_sym%0d", i), sym_data, exp_16qam(i));
      if (i == 1) begin
        check("s2_first_valid", at - k, 1156);
        check("s2_bits", sym_bits, 3'd4);
      end else begin
        check($sformatf("s2_spacing_%0d", i), at - prev, 1152);
      end
      prev = at;
    end

    // 64QAM with the consumer stalled across two ticks
    do_reset(2'b10, 2'b11);
    sym_ready = 1'b0;
    enable = 1'b1;
    wait_valid(1300, at);
    check("s3_sym1", sym_data, 6'd0);
    check("s3_bits", sym_bits, 3'd6);
    d0 = sym_data;
    ov = 0; drop = 0; chg = 0;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (sym_overrun) ov++;
      if (!sym_valid) drop++;
      if (sym_data !== d0) chg++;
    end
    check("s3_overrun_pulses", ov, 2);
    check("s3_valid_held", drop, 0);
    check("s3_data_held", chg, 0);
    sym_ready = 1'b1;
    @(negedge clk);
    check("s3_accept_valid", sym_valid, 1'b0);
    check("s3_accept_cnt", sym_cnt, 4'd1);
    wait_valid(1300, at);
    check("s3_sym2", sym_data, 6'd0);
    wait_valid(1300, at);
    check("s3_sym3", sym_data, 6'b001000);
    @(negedge clk);
    check("s3_cnt", sym_cnt, 4'd3);

    // Disable during the first SHIFT cycle of symbol 8, then resume
    do_reset(2'b00, 2'b11);
    sym_ready = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 7; i++) wait_valid(1300, at);
    repeat (1150) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("s5_disable_valid", sym_valid, 1'b0);
    vcount = 0;
    repeat (200) begin
      @(negedge clk);
      if (sym_valid) vcount++;
    end
    check("s5_idle_no_valid", vcount, 0);
    sym_ready = 1'b0;
    enable = 1'b1;
    wait_valid(1300, at);
    check("s5_resume_sym", sym_data, 6'd2);

    // Asynchronous reset while presenting
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", sym_valid, 1'b0);
    check("s5_rst_data", sym_data, 6'd0);
    check("s5_rst_cnt", sym_cnt, 4'd0);
    check("s5_rst_bits", sym_bits, 3'd2);
    @(negedge clk);
    rst_n = 1'b1;
    sym_ready = 1'b1;
    wait_valid(1300, at);
    check("s5_post_rst_sym1", sym_data, 6'd0);

    // Reserved mod_type and sym_cnt wrap with 4-bit counter
    do_reset(2'b11, 2'b11);
    sym_ready = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_valid(1300, at);
      check($sformatf("s6_sym%0d", i), sym_data, exp_qpsk(i));
      if (i == 1 || i == 16) check($sformatf("s6_bits%0d", i), sym_bits, 3'd2);
      if (i >= 15) begin
        @(negedge clk);
        check($sformatf("s6_cnt_after_%0d", i), sym_cnt, (i == 15) ? 4'd15 : 4'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
